// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
package ifetch_queue_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // addi x0,x0,0 -- also used by the IF/ID flush path
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch bus: memory request/response, redirect from ID, and decode handshake.
interface ifetch_queue_if #(
  parameter int DataWidth  = 32,
  parameter int InstrWidth = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [DataWidth-1:0]  mem_req_addr;
  logic                  mem_rsp_valid;
  logic [InstrWidth-1:0] mem_rsp_data;
  logic                  redirect_valid;
  logic [DataWidth-1:0]  redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [InstrWidth-1:0] instr;
  logic [DataWidth-1:0]  instr_pc;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; callers never push when full or pop when empty.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);

  logic [Depth-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/ifetch_queue.sv
// In-order fetch front end: credit-limited requests, response queue, redirect flush with stale-response discard.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                   DataWidth  = 32,
  parameter int                   InstrWidth = 32,
  parameter int                   Depth      = 4,
  parameter logic [DataWidth-1:0] ResetPC    = '0
) (
  input logic          clk,
  input logic          rst,
  ifetch_queue_if.master bus
);
  localparam int CW = $clog2(Depth+1);

  fetch_state_t         state_q;
  logic [CW-1:0]        out_q, disc_q, fifo_cnt, disc_new;
  logic [DataWidth-1:0] fetch_pc_q, rsp_pc_q, redir_pc;
  logic [CW:0]          inflight;
  logic                 credit, req_fire, push, pop, fifo_empty;
  logic [DataWidth+InstrWidth-1:0] head;
  logic                 unused_pc_lsb;

  assign inflight = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign credit   = inflight < (CW+1)'(Depth);
  // Reset gates the request combinationally so it drops the moment rst falls.
  assign bus.mem_req_valid = rst && credit && !bus.redirect_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign req_fire = bus.mem_req_valid && bus.mem_req_ready;

  assign push     = bus.mem_rsp_valid && !bus.redirect_valid && (state_q == RUN);
  assign pop      = !fifo_empty && bus.instr_ready && !bus.redirect_valid;
  assign redir_pc = {bus.redirect_pc[DataWidth-1:2], 2'b00};
  assign disc_new = out_q - CW'(bus.mem_rsp_valid);
  assign unused_pc_lsb = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      out_q      <= '0;
      disc_q     <= '0;
      fetch_pc_q <= ResetPC;
      rsp_pc_q   <= ResetPC;
    end else begin
      out_q <= out_q + CW'(req_fire) - CW'(bus.mem_rsp_valid);
      if (bus.redirect_valid) begin
        fetch_pc_q <= redir_pc;
        rsp_pc_q   <= redir_pc;
        disc_q     <= disc_new;
        state_q    <= (disc_new != '0) ? DRAIN : RUN;
      end else begin
        if (req_fire) fetch_pc_q <= fetch_pc_q + DataWidth'(4);
        if (push)     rsp_pc_q   <= rsp_pc_q + DataWidth'(4);
        if (state_q == DRAIN && bus.mem_rsp_valid) begin
          disc_q <= disc_q - CW'(1);
          if (disc_q == CW'(1)) state_q <= RUN;
        end
      end
    end
  end

  fetch_fifo #(.W(DataWidth+InstrWidth), .Depth(Depth)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .din_i   ({rsp_pc_q, bus.mem_rsp_data}),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? InstrWidth'(NOP_INSTR) : head[InstrWidth-1:0];
  assign bus.instr_pc    = fifo_empty ? '0 : head[DataWidth+InstrWidth-1:InstrWidth];
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and random checks of ifetch_queue against a queue-based reference of the fetch stream.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if #(.DataWidth(32), .InstrWidth(32)) bus ();

  ifetch_queue #(.DataWidth(32), .InstrWidth(32), .Depth(DEPTH), .ResetPC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  int vecs = 0;
  int errs = 0;
  ent_t        q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          outst, discard, cyc, fixed_lat;
  logic [31:0] m_fetch, m_rsp;
  logic        last_req_valid;
  logic [31:0] last_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend_addr.delete();
    pend_due.delete();
    outst   = 0;
    discard = 0;
    m_fetch = 32'h0;
    m_rsp   = 32'h0;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model at posedge.
  task automatic step(input bit rr, input bit ir, input bit redir, input logic [31:0] rpc);
    bit          exp_req, rv;
    logic [31:0] rd;
    int          lat, o_old;
    @(negedge clk);
    cyc++;
    rv = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    rd = rv ? memf(pend_addr[0]) : $urandom;
    bus.mem_req_ready  = rr;
    bus.instr_ready    = ir;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.mem_rsp_valid  = rv;
    bus.mem_rsp_data   = rd;
    #1;
    exp_req = (outst + q.size() < DEPTH) && !redir;
    chk("req_valid", 32'(bus.mem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", bus.mem_req_addr, m_fetch);
    chk("instr_valid", 32'(bus.instr_valid), 32'(q.size() != 0));
    chk("instr", bus.instr, (q.size() != 0) ? q[0].ins : NOP_INSTR);
    chk("instr_pc", bus.instr_pc, (q.size() != 0) ? q[0].pc : 32'h0);
    last_req_valid = bus.mem_req_valid;
    last_addr      = bus.mem_req_addr;
    @(posedge clk);
    o_old = outst;
    if (exp_req && rr) begin
      lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      pend_addr.push_back(m_fetch);
      pend_due.push_back(cyc + lat);
      m_fetch += 32'd4;
      outst++;
    end
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      outst--;
    end
    if (redir) begin
      q.delete();
      m_fetch = rpc & ~32'h3;
      m_rsp   = rpc & ~32'h3;
      discard = o_old - int'(rv);
    end else begin
      if (q.size() != 0 && ir) void'(q.pop_front());
      if (rv) begin
        if (discard > 0) discard--;
        else begin
          q.push_back('{pc: m_rsp, ins: rd});
          m_rsp += 32'd4;
        end
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bus.mem_req_ready  = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, NOP_INSTR);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    #1 rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int          k;
    logic [31:0] rpc;
    bus.mem_req_ready  = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
    cyc       = 0;
    fixed_lat = 1;
    model_reset();

    // Held in reset
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("reset_instr_valid", 32'(bus.instr_valid), 32'h0);
    chk("reset_instr", bus.instr, NOP_INSTR);
    chk("reset_instr_pc", bus.instr_pc, 32'h0);
    rst = 1'b1;

    // Back-to-back requests from ResetPC with 1-cycle memory
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_req_valid", 32'(last_req_valid), 32'h1);
      chk("first_req_addr", last_addr, 32'(4 * i));
    end

    // Decode stall: credits run out
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_stall", 32'(last_req_valid), 32'h0);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with requests in flight
    fixed_lat = 3;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_addr", last_addr, 32'h100);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coincident with a response and a pop
    fixed_lat = 1;
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap and alignment of the redirect target
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_hi", last_addr, 32'hFFFF_FFFC);
    k = 0;
    while (!last_req_valid && k < 20) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      k++;
    end
    chk("wrap_fire", 32'(last_req_valid), 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_lo", last_addr, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h103);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("align", last_addr, 32'h100);

    // Asynchronous reset while stale responses are still owed
    fixed_lat = 4;
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    reset_pulse();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_addr", last_addr, 32'h0);
    chk("restart_valid", 32'(last_req_valid), 32'h1);

    // Random traffic
    fixed_lat = 0;
    repeat (3000) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 4095));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
